// File: rtl/weight_fetch_scheduler_if.sv
// ---------------------------------------------------------------------------
// weight_fetch_scheduler_if
//
// Purpose: bundles the request side (boot/spike/accumulator handshake) and the
// memory/accumulator side of the weight fetch scheduler.
//
// Signals:
//   boot_mode      scheduler input   high selects bias fetch, masks spikes
//   spike_in       scheduler input   per-neuron spike pulses
//   acc_ready      scheduler input   accumulator can accept data
//   mem_addr       scheduler output  weight memory read address
//   mem_en         scheduler output  read enable, one read per high cycle
//   data_valid     scheduler output  read data valid (mem_en delayed RD_LAT)
//   burst_start    scheduler output  first data_valid of a burst
//   burst_done     scheduler output  last data_valid of a burst
//   burst_id       scheduler output  granted neuron, 0 for bias
//   burst_is_bias  scheduler output  current burst is the bias burst
//   pending        scheduler output  pending-request register
//   overrun        scheduler output  spike hit an already-pending neuron
//
// Modports: master = scheduler, slave = environment driving the requests.
// ---------------------------------------------------------------------------
interface weight_fetch_scheduler_if #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = 10
);
  logic                 boot_mode;
  logic [N_NEURONS-1:0] spike_in;
  logic                 acc_ready;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_en;
  logic                 data_valid;
  logic                 burst_start;
  logic                 burst_done;
  logic [2:0]           burst_id;
  logic                 burst_is_bias;
  logic [N_NEURONS-1:0] pending;
  logic                 overrun;

  modport master (
    input  boot_mode, spike_in, acc_ready,
    output mem_addr, mem_en, data_valid, burst_start, burst_done,
           burst_id, burst_is_bias, pending, overrun
  );

  modport slave (
    output boot_mode, spike_in, acc_ready,
    input  mem_addr, mem_en, data_valid, burst_start, burst_done,
           burst_id, burst_is_bias, pending, overrun
  );
endinterface

// File: rtl/weight_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// weight_fetch_scheduler
//
// Purpose: arbiter and sequencer for the single synaptic-weight read port.
// Spikes are collected into a pending register; one neuron at a time is
// granted and a BURST_LEN-word address burst is issued from its weight region
// (base = id * BURST_LEN). A rising edge of boot_mode (or boot_mode high at
// reset release) arms one bias burst from BIAS_BASE, which has priority.
// data_valid/burst_start/burst_done are the issue strobes delayed by RD_LAT so
// they line up with the returning read data.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    weight_fetch_scheduler_if.master (see interface header)
//
// Build option:
//   WFS_ROUND_ROBIN_EN  defined   -> round-robin grant starting at pointer+1,
//                                    pointer moves to each neuron winner
//                       undefined -> fixed priority, lowest index wins
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for acc_ready with an armed bias or a pending neuron
// GRANT | latch winner/base/id, clear its request, zero the word counter
// BURST | issue one read per acc_ready cycle, hold while acc_ready is low
// DRAIN | wait for the last read's data_valid to leave the pipe
// ---------------------------------------------------------------------------
module weight_fetch_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int BURST_LEN = 15,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 2,
  parameter int BIAS_BASE = 120
) (
  input  logic clk,
  input  logic rst_n,
  weight_fetch_scheduler_if.master bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int ID_W  = 3;
  localparam logic [N_NEURONS-1:0] ONE_HOT0 = N_NEURONS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BURST = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [N_NEURONS-1:0] r_pending;
  logic                 r_bias_armed;
  logic                 r_boot_q;
  logic [ADDR_W-1:0]    r_base;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_burst_id;
  logic                 r_is_bias;
  logic                 r_overrun;
  logic [RD_LAT-1:0]    r_v_pipe;
  logic [RD_LAT-1:0]    r_first_pipe;
  logic [RD_LAT-1:0]    r_last_pipe;

`ifdef WFS_ROUND_ROBIN_EN
  logic [ID_W-1:0]      r_ptr;
`endif

  logic                 w_issue;
  logic                 w_first_word;
  logic                 w_last_word;
  logic                 w_last_out;
  logic                 w_grant;
  logic                 w_grant_bias;
  logic                 w_win_found;
  logic [ID_W-1:0]      w_win_id;
  logic [ID_W-1:0]      w_idx;
  logic [N_NEURONS-1:0] w_clr;
  logic [N_NEURONS-1:0] w_spike_masked;
  logic                 w_boot_rise;

  assign w_issue        = (r_state == S_BURST) && bus.acc_ready;
  assign w_first_word   = (r_cnt == '0);
  assign w_last_word    = (r_cnt == CNT_W'(BURST_LEN - 1));
  assign w_last_out     = r_last_pipe[RD_LAT-1];
  assign w_grant        = (r_state == S_GRANT);
  assign w_grant_bias   = w_grant && r_bias_armed;
  assign w_spike_masked = bus.boot_mode ? '0 : bus.spike_in;
  assign w_boot_rise    = bus.boot_mode && !r_boot_q;

  // Winner search over the pending register.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
`ifdef WFS_ROUND_ROBIN_EN
    for (int k = 1; k <= N_NEURONS; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_NEURONS);
      if (!w_win_found && r_pending[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
`else
    for (int k = 0; k < N_NEURONS; k++) begin
      w_idx = ID_W'(k);
      if (!w_win_found && r_pending[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
`endif
  end

  // A bias grant leaves pending untouched.
  always_comb begin
    w_clr = '0;
    if (w_grant && !r_bias_armed && w_win_found) begin
      w_clr = ONE_HOT0 << w_win_id;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.acc_ready &&
            (r_bias_armed || ((|r_pending) && !bus.boot_mode))) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: w_state_nxt = S_BURST;
      S_BURST: begin
        if (w_issue && w_last_word) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_out) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Requests: a spike in the grant cycle re-sets the bit being cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_bias_armed <= 1'b0;
      r_boot_q     <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_spike_masked;
      r_boot_q  <= bus.boot_mode;
      r_overrun <= |(w_spike_masked & r_pending);
      // r_boot_q resets low, so boot_mode high at release counts as an edge.
      if (w_boot_rise) begin
        r_bias_armed <= 1'b1;
      end else if (w_grant_bias) begin
        r_bias_armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_burst_id <= '0;
      r_is_bias  <= 1'b0;
    end else if (w_grant) begin
      r_cnt      <= '0;
      r_is_bias  <= r_bias_armed;
      r_burst_id <= r_bias_armed ? '0 : w_win_id;
      r_base     <= r_bias_armed ? ADDR_W'(BIAS_BASE)
                                 : ADDR_W'(w_win_id) * ADDR_W'(BURST_LEN);
    end else if (w_issue) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef WFS_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant && !r_bias_armed && w_win_found) begin
      r_ptr <= w_win_id;
    end
  end
`endif

  // Bit 0 is the newest issue; bit RD_LAT-1 lines up with returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_pipe     <= '0;
      r_first_pipe <= '0;
      r_last_pipe  <= '0;
    end else begin
      r_v_pipe     <= RD_LAT'({r_v_pipe, w_issue});
      r_first_pipe <= RD_LAT'({r_first_pipe, w_issue && w_first_word});
      r_last_pipe  <= RD_LAT'({r_last_pipe, w_issue && w_last_word});
    end
  end

  assign bus.mem_en        = w_issue;
  assign bus.mem_addr      = (r_state == S_BURST) ? (r_base + ADDR_W'(r_cnt)) : '0;
  assign bus.data_valid    = r_v_pipe[RD_LAT-1];
  assign bus.burst_start   = r_first_pipe[RD_LAT-1];
  assign bus.burst_done    = r_last_pipe[RD_LAT-1];
  assign bus.burst_id      = r_burst_id;
  assign bus.burst_is_bias = r_is_bias;
  assign bus.pending       = r_pending;
  assign bus.overrun       = r_overrun;

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
module tb_weight_fetch_scheduler;
  localparam int N  = 8;
  localparam int BL = 15;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int BB = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  weight_fetch_scheduler_if #(.N_NEURONS(N), .ADDR_W(AW)) bus ();

  weight_fetch_scheduler #(
    .N_NEURONS(N), .BURST_LEN(BL), .ADDR_W(AW), .RD_LAT(RL), .BIAS_BASE(BB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One burst is described by when it was granted and how many words it has
  // issued; read data is tracked as a cycle-indexed history of issued words.
  logic [7:0] m_pend;
  bit         m_armed, m_bprev, m_ovr, m_active, m_grant_now, m_bias;
  int         m_words, m_free_at, m_base, m_id;
  int         hist[64];
`ifdef WFS_ROUND_ROBIN_EN
  int         m_ptr;
  function automatic int pick(input logic [7:0] p);
    for (int k = 1; k <= N; k++) if (p[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction
`else
  function automatic int pick(input logic [7:0] p);
    for (int k = 0; k < N; k++) if (p[k]) return k;
    return 0;
  endfunction
`endif

  // ---------------- event monitor for literal checks ----------------
  int first_en, last_en, first_addr, last_addr, done_cyc, start_cyc;
  int en_cnt, dv_cnt, start_cnt, done_cnt, ovr_cnt;
  int id_q[$];
  int bias_q[$];

  task automatic clear_mon();
    first_en = -1; last_en = -1; first_addr = -1; last_addr = -1;
    done_cyc = -1; start_cyc = -1;
    en_cnt = 0; dv_cnt = 0; start_cnt = 0; done_cnt = 0; ovr_cnt = 0;
    id_q.delete(); bias_q.delete();
  endtask

  always @(negedge clk) begin
    bit        in_b, e_en, e_dv, e_st, e_dn, novr, brd, rdy;
    int        h, w, e_addr;
    logic [7:0] clr, spk;
    if (!rst_n) begin
      m_pend = '0; m_armed = 0; m_bprev = 0; m_ovr = 0; m_active = 0;
      m_grant_now = 0; m_bias = 0; m_words = 0; m_free_at = 0; m_base = 0; m_id = 0;
`ifdef WFS_ROUND_ROBIN_EN
      m_ptr = 0;
`endif
      for (int i = 0; i < 64; i++) hist[i] = -1;
      chk("rst_mem_en", 32'(bus.mem_en), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_data_valid", 32'(bus.data_valid), 0);
      chk("rst_burst_done", 32'(bus.burst_done), 0);
      chk("rst_pending", 32'(bus.pending), 0);
      chk("rst_burst_id", 32'(bus.burst_id), 0);
    end else begin
      brd = bus.boot_mode; rdy = bus.acc_ready; spk = bus.spike_in;
      in_b   = m_active && !m_grant_now && (m_words < BL);
      e_en   = in_b && rdy;
      e_addr = in_b ? ((m_base + m_words) % (1 << AW)) : 0;
      h      = hist[(cyc + 64 - RL) % 64];
      e_dv   = (h >= 0);
      e_st   = (h == 0);
      e_dn   = (h == BL - 1);
      chk("mem_en", 32'(bus.mem_en), 32'(e_en));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("data_valid", 32'(bus.data_valid), 32'(e_dv));
      chk("burst_start", 32'(bus.burst_start), 32'(e_st));
      chk("burst_done", 32'(bus.burst_done), 32'(e_dn));
      chk("burst_id", 32'(bus.burst_id), 32'(m_id));
      chk("burst_is_bias", 32'(bus.burst_is_bias), 32'(m_bias));
      chk("pending", 32'(bus.pending), 32'(m_pend));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));

      if (bus.mem_en) begin
        en_cnt++;
        if (first_en < 0) begin first_en = cyc; first_addr = int'(bus.mem_addr); end
        last_en = cyc; last_addr = int'(bus.mem_addr);
      end
      if (bus.data_valid) dv_cnt++;
      if (bus.burst_start) begin
        start_cnt++; start_cyc = cyc;
        id_q.push_back(int'(bus.burst_id)); bias_q.push_back(int'(bus.burst_is_bias));
      end
      if (bus.burst_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.overrun) ovr_cnt++;

      // advance the model to the next cycle
      novr = !brd && ((spk & m_pend) != 0);
      clr  = '0;
      hist[cyc % 64] = -1;
      if (m_active && m_grant_now) begin
        if (m_armed) begin
          m_bias = 1; m_id = 0; m_base = BB; m_armed = 0;
        end else begin
          w = pick(m_pend);
          m_bias = 0; m_id = w; m_base = w * BL; clr[w] = 1'b1;
`ifdef WFS_ROUND_ROBIN_EN
          m_ptr = w;
`endif
        end
        m_words = 0; m_grant_now = 0;
      end else if (m_active) begin
        if (m_words < BL && rdy) begin
          hist[cyc % 64] = m_words;
          m_words++;
          if (m_words == BL) m_free_at = cyc + RL + 1;
        end else if (m_words == BL && cyc + 1 >= m_free_at) begin
          m_active = 0;
        end
      end else if (rdy && (m_armed || (m_pend != 0 && !brd))) begin
        m_active = 1; m_grant_now = 1;
      end
      if (brd && !m_bprev) m_armed = 1;
      m_bprev = brd;
      m_pend  = (m_pend & ~clr) | (brd ? 8'h00 : spk);
      m_ovr   = novr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t;
    clear_mon();
    bus.boot_mode = 1'b1;
    bus.spike_in  = '0;
    bus.acc_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();

    // reset release with boot_mode high -> one bias burst 120..134
    clear_mon();
    rst_n = 1'b1;
    repeat (45) tick();
    chk("boot_starts", 32'(start_cnt), 1);
    chk("boot_dones", 32'(done_cnt), 1);
    chk("boot_valids", 32'(dv_cnt), 15);
    chk("boot_first_addr", 32'(first_addr), 120);
    chk("boot_last_addr", 32'(last_addr), 134);
    chk("boot_is_bias", 32'(bias_q.size() > 0 ? bias_q[0] : -1), 1);
    bus.boot_mode = 1'b0;
    repeat (4) tick();

    // single spike on neuron 2: latency pinning
    clear_mon();
    t = cyc;
    bus.spike_in = 8'h04;
    tick();
    bus.spike_in = 8'h00;
    repeat (30) tick();
    chk("n2_first_en_cyc", 32'(first_en), 32'(t + 3));
    chk("n2_first_addr", 32'(first_addr), 30);
    chk("n2_last_en_cyc", 32'(last_en), 32'(t + 17));
    chk("n2_last_addr", 32'(last_addr), 44);
    chk("n2_start_cyc", 32'(start_cyc), 32'(t + 5));
    chk("n2_done_cyc", 32'(done_cyc), 32'(t + 19));
    chk("n2_id", 32'(id_q.size() > 0 ? id_q[0] : -1), 2);

    // all neurons spike at once, fresh pointer
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    clear_mon();
    bus.spike_in = 8'hFF;
    tick();
    bus.spike_in = 8'h00;
    repeat (200) tick();
    chk("ff_starts", 32'(start_cnt), 8);
    chk("ff_valids", 32'(dv_cnt), 120);
    for (int k = 0; k < 8; k++) begin
`ifdef WFS_ROUND_ROBIN_EN
      chk("ff_order", 32'(id_q.size() > k ? id_q[k] : -1), 32'((k + 1) % 8));
`else
      chk("ff_order", 32'(id_q.size() > k ? id_q[k] : -1), 32'(k));
`endif
    end

    // acc_ready stall at word 5 of neuron 1
    clear_mon();
    t = cyc;
    bus.spike_in = 8'h02;
    tick();
    bus.spike_in = 8'h00;
    repeat (7) tick();
    bus.acc_ready = 1'b0;
    tick();
    chk("stall_addr_hold", 32'(bus.mem_addr), 20);
    chk("stall_en_low", 32'(bus.mem_en), 0);
    repeat (2) tick();
    bus.acc_ready = 1'b1;
    #1;
    chk("stall_resume_en", 32'(bus.mem_en), 1);
    chk("stall_resume_addr", 32'(bus.mem_addr), 20);
    repeat (25) tick();
    chk("stall_valids", 32'(dv_cnt), 15);
    chk("stall_enables", 32'(en_cnt), 15);
    chk("stall_last_addr", 32'(last_addr), 29);

    // accumulate with acc_ready low, overrun on neuron 3
    bus.acc_ready = 1'b0;
    clear_mon();
    bus.spike_in = 8'h08;
    tick();
    bus.spike_in = 8'h00;
    tick();
    bus.spike_in = 8'h08;
    tick();
    bus.spike_in = 8'h20;
    tick();
    bus.spike_in = 8'h00;
    chk("acc_pending", 32'(bus.pending), 32'h28);
    chk("ovr_pulses", 32'(ovr_cnt), 1);
    bus.acc_ready = 1'b1;
    repeat (60) tick();
    chk("ovr_starts", 32'(start_cnt), 2);
    chk("ovr_first_id", 32'(id_q.size() > 0 ? id_q[0] : -1), 3);
    chk("ovr_second_id", 32'(id_q.size() > 1 ? id_q[1] : -1), 5);

    // reset mid-burst on neuron 4
    clear_mon();
    bus.spike_in = 8'h10;
    tick();
    bus.spike_in = 8'h00;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", 32'(bus.mem_en), 0);
    chk("abort_mem_addr", 32'(bus.mem_addr), 0);
    chk("abort_burst_id", 32'(bus.burst_id), 0);
    chk("abort_data_valid", 32'(bus.data_valid), 0);
    repeat (2) tick();
    chk("abort_no_done", 32'(done_cnt), 0);
    rst_n = 1'b1;
    clear_mon();
    repeat (30) tick();
    chk("after_abort_en", 32'(en_cnt), 0);
    chk("after_abort_done", 32'(done_cnt), 0);

    // boot_mode rises during a neuron-6 burst -> bias follows
    clear_mon();
    bus.spike_in = 8'h40;
    tick();
    bus.spike_in = 8'h00;
    repeat (8) tick();
    bus.boot_mode = 1'b1;
    repeat (60) tick();
    chk("bootmid_starts", 32'(start_cnt), 2);
    chk("bootmid_dones", 32'(done_cnt), 2);
    chk("bootmid_id0", 32'(id_q.size() > 0 ? id_q[0] : -1), 6);
    chk("bootmid_bias0", 32'(bias_q.size() > 0 ? bias_q[0] : -1), 0);
    chk("bootmid_bias1", 32'(bias_q.size() > 1 ? bias_q[1] : -1), 1);
    chk("bootmid_last_addr", 32'(last_addr), 134);
    bus.boot_mode = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
